midi_voice_alloc: RTL
=====================

# midi_voice_alloc

Polyphonic voice allocator sitting directly downstream of the MIDI decoder. Consumes each complete MIDI message (status, data1, data2 plus ready flag) and maps Note On/Off events onto a fixed pool of synth voices, producing per-voice gate, note, velocity and retrigger pulses for the oscillator/envelope stages. Also tracks pitch bend and handles All Notes Off.

## Interface
- NUM_VOICES, 4: voice count, 2..16.
- OMNI, 1: 1 = accept all channels; 0 = accept only CHANNEL.
- CHANNEL, 0: 4-bit MIDI channel used when OMNI=0.

- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- midi_byte_ready  in  1  level from decoder; held high ≥1 cycle per message.
- midi_byte0  in  8  status byte.
- midi_byte1  in  8  data1 byte.
- midi_byte2  in  8  data2 byte.
- voice_gate  out  NUM_VOICES  per-voice key-down.
- voice_note  out  7*NUM_VOICES  note number; voice i at [7i+6:7i].
- voice_velocity  out  7*NUM_VOICES  velocity; same packing.
- voice_trigger  out  NUM_VOICES  one-cycle pulse on (re)allocation.
- pitch_bend  out  14  last bend value, 0x2000 = centre.

## Operation
- Message acceptance on the rising edge of midi_byte_ready only; a level held high is one message. Edge register resets to 1, so a level already high at reset release is ignored.
- Bytes latched on the accepting edge; decoder outputs may change afterwards.
- Channel filter: when OMNI=0, messages with midi_byte0[3:0] != CHANNEL are dropped with no state change.
- FSM: IDLE -> MATCH -> APPLY -> IDLE.
  - IDLE: wait for edge, latch bytes.
  - MATCH: compute and register the target voice.
  - APPLY: update voice state, pulse trigger.
- Rising edges arriving outside IDLE are dropped. At MIDI rates this is unreachable.
- Note On is 0x9n with data2 != 0. Target voice priority:
  1. voice with gate=1 and the same note (retrigger);
  2. lowest-index voice with gate=0;
  3. steal the voice with the highest age, ties to the lowest index.
- Note On effects:
  - target: gate=1, note=data1[6:0], velocity=data2[6:0], trigger pulse, age=0;
  - every other voice with gate=1: age+1, saturating at 255.
- Note Off is 0x8n, or 0x9n with data2=0. Every voice with gate=1 and a matching note clears its gate. Note and velocity are retained for release. No trigger.
- Pitch bend 0xEn: pitch_bend = {data2[6:0], data1[6:0]}.
- Control change 0xBn with data1 = 120 or 123: all gates cleared, ages cleared.
- All other statuses are ignored.
- Data bytes are masked to 7 bits.

## Timing
- Edge sampled at clk edge E0: bytes latched at E0, MATCH at E1, APPLY registers update at E2. Outputs are valid after E2 (3-cycle latency).
- voice_trigger is high exactly the cycle after E2, coincident with the first cycle of updated gate/note.
- Reset values:
  - voice_gate, voice_note, voice_velocity, voice_trigger, ages: 0;
  - pitch_bend: 0x2000;
  - FSM: IDLE.
- Reset asserted mid-operation aborts the message; no partial update survives.
- Only one voice changes per Note On. Note Off may clear several voices with the same note.

## Test plan
- Reset release with midi_byte_ready=1 and bytes 90/3C/40 -> no voice change. Then drop ready and raise it again -> voice0 gate=1, note=0x3C, vel=0x40, trigger[0] pulses once, 3 cycles after the edge.
- Note On 3C, 40, 43, 47 (vel 0x50), then 48 -> voices 0..3 fill in order. The fifth note steals voice0 (oldest): note=0x48, trigger[0] pulses.
- Note On 3C, then 90/3C/00 -> gate[0]=0, note stays 0x3C. Then 80/3C/xx on an empty pool -> no change.
- Note On 3C vel 0x40, then 3C vel 0x7F -> same voice0 retriggered, vel=0x7F, voice1 untouched.
- E0/00/40 -> pitch_bend=0x2000. E0/7F/7F -> 0x3FFF. B0/7B/00 with 3 gates active -> voice_gate=0.
- OMNI=0, CHANNEL=2: 91/3C/40 -> ignored; 92/3C/40 -> voice0 allocated. Assert reset during MATCH -> all outputs return to reset values.

Source files
------------

// File: rtl/midi_voice_alloc.sv
// Polyphonic voice allocator: maps decoded MIDI Note On/Off, pitch bend and
// All Notes Off onto a fixed pool of voices with retrigger/free/steal priority.
module midi_voice_alloc #(
   parameter int unsigned NUM_VOICES = 4,
   parameter bit          OMNI       = 1'b1,
   parameter logic [3:0]  CHANNEL    = 4'd0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      midi_byte_ready,
   input  logic [7:0]                midi_byte0,
   input  logic [7:0]                midi_byte1,
   input  logic [7:0]                midi_byte2,
   output logic [NUM_VOICES-1:0]     voice_gate,
   output logic [7*NUM_VOICES-1:0]   voice_note,
   output logic [7*NUM_VOICES-1:0]   voice_velocity,
   output logic [NUM_VOICES-1:0]     voice_trigger,
   output logic [13:0]               pitch_bend
);

   localparam int unsigned IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   localparam int unsigned AGE_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_MATCH = 2'd1,
      ST_APPLY = 2'd2
   } state_t;

   state_t                            state_q, state_d;
   logic                              rdy_q, rdy_d;
   logic [3:0]                        status_q, status_d;
   logic [6:0]                        data1_q, data1_d;
   logic [6:0]                        data2_q, data2_d;
   logic [IDX_W-1:0]                  target_q, target_d;
   logic [NUM_VOICES-1:0]             gate_q, gate_d;
   logic [NUM_VOICES-1:0][6:0]        note_q, note_d;
   logic [NUM_VOICES-1:0][6:0]        vel_q, vel_d;
   logic [NUM_VOICES-1:0][AGE_W-1:0]  age_q, age_d;
   logic [NUM_VOICES-1:0]             trig_q, trig_d;
   logic [13:0]                       bend_q, bend_d;

   logic                              rise_c;
   logic                              chan_ok_c;
   logic                              note_on_c, note_off_c, bend_c, all_off_c;
   logic [IDX_W-1:0]                  target_c;
   logic                              unused_bits_c;

   assign rise_c        = midi_byte_ready & ~rdy_q;
   assign chan_ok_c     = OMNI || (midi_byte0[3:0] == CHANNEL);
   assign unused_bits_c = ^{midi_byte1[7], midi_byte2[7]};

   assign note_on_c  = (status_q == 4'h9) && (data2_q != 7'd0);
   assign note_off_c = (status_q == 4'h8) || ((status_q == 4'h9) && (data2_q == 7'd0));
   assign bend_c     = (status_q == 4'hE);
   assign all_off_c  = (status_q == 4'hB) && ((data1_q == 7'd120) || (data1_q == 7'd123));

   // Target voice: held same note, else lowest free, else oldest (ties low).
   always_comb begin
      logic             match_found, free_found;
      logic [IDX_W-1:0] match_idx, free_idx, old_idx;
      logic [AGE_W-1:0] old_age;
      match_found = 1'b0;
      free_found  = 1'b0;
      match_idx   = '0;
      free_idx    = '0;
      old_idx     = '0;
      old_age     = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         if (!match_found && gate_q[i] && (note_q[i] == data1_q)) begin
            match_found = 1'b1;
            match_idx   = IDX_W'(i);
         end
         if (!free_found && !gate_q[i]) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
         if (age_q[i] > old_age) begin
            old_age = age_q[i];
            old_idx = IDX_W'(i);
         end
      end
      target_c = match_found ? match_idx : (free_found ? free_idx : old_idx);
   end

   always_comb begin
      state_d  = state_q;
      rdy_d    = midi_byte_ready;
      status_d = status_q;
      data1_d  = data1_q;
      data2_d  = data2_q;
      target_d = target_q;
      gate_d   = gate_q;
      note_d   = note_q;
      vel_d    = vel_q;
      age_d    = age_q;
      trig_d   = '0;
      bend_d   = bend_q;
      case (state_q)
         ST_IDLE: begin
            if (rise_c && chan_ok_c) begin
               status_d = midi_byte0[7:4];
               data1_d  = midi_byte1[6:0];
               data2_d  = midi_byte2[6:0];
               state_d  = ST_MATCH;
            end
         end
         ST_MATCH: begin
            target_d = target_c;
            state_d  = ST_APPLY;
         end
         ST_APPLY: begin
            state_d = ST_IDLE;
            if (note_on_c) begin
               for (int i = 0; i < NUM_VOICES; i++) begin
                  if (IDX_W'(i) == target_q) begin
                     gate_d[i] = 1'b1;
                     note_d[i] = data1_q;
                     vel_d[i]  = data2_q;
                     trig_d[i] = 1'b1;
                     age_d[i]  = '0;
                  end else if (gate_q[i] && (age_q[i] != {AGE_W{1'b1}})) begin
                     age_d[i] = age_q[i] + AGE_W'(1);
                  end
               end
            end else if (note_off_c) begin
               for (int i = 0; i < NUM_VOICES; i++) begin
                  if (gate_q[i] && (note_q[i] == data1_q)) begin
                     gate_d[i] = 1'b0;
                  end
               end
            end else if (bend_c) begin
               bend_d = {data2_q, data1_q};
            end else if (all_off_c) begin
               gate_d = '0;
               age_d  = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Edge register resets high so a level already present at release is ignored.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         rdy_q    <= 1'b1;
         status_q <= '0;
         data1_q  <= '0;
         data2_q  <= '0;
         target_q <= '0;
         gate_q   <= '0;
         note_q   <= '0;
         vel_q    <= '0;
         age_q    <= '0;
         trig_q   <= '0;
         bend_q   <= 14'h2000;
      end else begin
         state_q  <= state_d;
         rdy_q    <= rdy_d;
         status_q <= status_d;
         data1_q  <= data1_d;
         data2_q  <= data2_d;
         target_q <= target_d;
         gate_q   <= gate_d;
         note_q   <= note_d;
         vel_q    <= vel_d;
         age_q    <= age_d;
         trig_q   <= trig_d;
         bend_q   <= bend_d;
      end
   end

   assign voice_gate     = gate_q;
   assign voice_note     = note_q;
   assign voice_velocity = vel_q;
   assign voice_trigger  = trig_q;
   assign pitch_bend     = bend_q;

endmodule
